instruction_block_fetch_unit: RTL
=================================

# instruction_block_fetch_unit

Services block-fill requests from the instruction cache. It accepts a 26-bit block address on the cache's L2 address channel and reads the 16 words of that block from a 32-bit word-wide memory port. It assembles them into one 512-bit line and returns that line on the cache's L2 data channel. It sits directly upstream of the instruction cache, replacing the behavioural L2 emulator used in cache simulation.

## Interface
- ADDRESS_WIDTH, 32, byte address width on memory side
- WORD_SIZE, 4, bytes per word
- WORD_PER_BLOCK, 16, words per cache line
- L2_BUS_WIDTH, 32, memory data bus width; must equal WORD_SIZE*8
- Derived: WORD_WIDTH = 32, BLOCK_WIDTH = 512, BLOCK_ADDRESS_WIDTH = ADDRESS_WIDTH - log2(WORD_PER_BLOCK) - log2(WORD_SIZE) = 26
- CLK  in  1  single clock; all logic on rising edge
- RSTN  in  1  reset, synchronous, active-low
- ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE  in  1  block request valid
- ADDRESS_TO_L2_READY_INSTRUCTION_CACHE  out  1  request can be accepted
- ADDRESS_TO_L2_INSTRUCTION_CACHE  in  26  block address
- DATA_FROM_L2_VALID_INSTRUCTION_CACHE  out  1  assembled line valid
- DATA_FROM_L2_READY_INSTRUCTION_CACHE  in  1  cache accepts line
- DATA_FROM_L2_INSTRUCTION_CACHE  out  512  assembled line
- MEM_READ_VALID  out  1  word read request valid
- MEM_READ_READY  in  1  memory accepts read request
- MEM_ADDRESS  out  32  word byte address
- MEM_DATA_VALID  in  1  returned word valid; no backpressure
- MEM_DATA  in  32  returned word, in request order

## Operation
- FSM states: IDLE, FETCH, RESPOND.
- IDLE:
  - ADDRESS_TO_L2_READY = 1.
  - On a request handshake (valid & ready), the block address is latched, both counters are cleared, and the FSM moves to FETCH.
- FETCH:
  - Issue counter issue_cnt runs 0..15. MEM_READ_VALID = 1 while issue_cnt < 16.
  - MEM_ADDRESS = {block_addr, issue_cnt[3:0], 2'b00}.
  - issue_cnt increments on each MEM_READ_VALID & MEM_READ_READY.
- Receive counter rcv_cnt runs 0..15 and increments on MEM_DATA_VALID.
  - Word rcv_cnt is written to line bits [BLOCK_WIDTH-1-32*rcv_cnt -: 32]; word 0 is the most significant.
  - Up to 16 reads may be outstanding. Returns are strictly in order.
- When the 16th word is received, the FSM moves to RESPOND.
- RESPOND:
  - DATA_FROM_L2_VALID = 1 and the line is held stable until DATA_FROM_L2_READY = 1.
  - After the handshake the FSM moves to IDLE.
- MEM_DATA_VALID outside FETCH is ignored. This covers stale returns after reset.
- DATA_FROM_L2_INSTRUCTION_CACHE is forced to all-zero whenever DATA_FROM_L2_VALID = 0.

## Timing
- Reset values:
  - All outputs are 0, including ADDRESS_TO_L2_READY.
  - FSM = IDLE; counters and line register cleared.
  - ADDRESS_TO_L2_READY rises in the first cycle after RSTN deasserts.
- Reset mid-FETCH or mid-RESPOND abandons the transaction with no response. Reset dominates every simultaneous event.
- Request accepted at edge T:
  - MEM_READ_VALID is first high in cycle T+1.
  - With MEM_READ_READY tied high and 1-cycle memory latency, reads issue in cycles T+1..T+16 and words return in T+2..T+17.
  - DATA_FROM_L2_VALID rises in cycle T+18 (minimum latency 18).
- MEM_READ_READY low stalls issue_cnt and holds MEM_ADDRESS stable.
- MEM_READ_VALID drops the cycle after the 16th issue handshake.
- The issue and receive handshakes may occur in the same cycle; both counters update.

## Configuration
- REQUEST_BUFFER_EN defined:
  - A one-entry request buffer keeps ADDRESS_TO_L2_READY = 1 during FETCH and RESPOND while the buffer is empty.
  - After the response handshake, a buffered address goes directly to FETCH with no IDLE cycle.
  - A simultaneous response handshake and new request in RESPOND with an empty buffer also goes directly to FETCH.
- REQUEST_BUFFER_EN undefined: ADDRESS_TO_L2_READY = 1 only in IDLE; no buffer logic.

## Structure
- A shared header holds the FSM state encodings, WORD_WIDTH, BLOCK_WIDTH, BLOCK_ADDRESS_WIDTH, and word-index width localparams. These are shared with the instruction cache.
- One sub-module, block_assembly_register, holds the 512-bit line register, the receive counter, and the word-slot write logic. The top level keeps the FSM, the issue counter, and the optional buffer.

## Test plan
- Memory always ready, 1-cycle latency, word k = 0x1000_0000+k; request block address 0 -> reads at 0x00..0x3C, DATA_FROM_L2_VALID at T+18, line MSB word = 0x1000_0000, LSB word = 0x1000_000F.
- Request block address 0x2 with MEM_READ_READY toggling every other cycle -> MEM_ADDRESS 0x80..0xBC issued in order, line correct, no word duplicated or skipped.
- DATA_FROM_L2_READY held low 5 cycles in RESPOND -> valid and line stable all 5 cycles, and ADDRESS_TO_L2_READY = 0 when REQUEST_BUFFER_EN is undefined.
- RSTN low after 7 words received, then a stray MEM_DATA_VALID -> no response, all outputs 0, READY = 1 the cycle after release, and the next request returns the correct line.
- REQUEST_BUFFER_EN defined: second request (address 0x1) during FETCH -> accepted, FSM goes from RESPOND directly to FETCH, and the second line's reads start at 0x40.

Source files
------------

// File: rtl/instruction_block_fetch_unit_pkg.sv
// Shared definitions for the instruction cache block-fill path: bus geometry and fetch FSM states.
package instruction_block_fetch_unit_pkg;

   localparam int ADDRESS_WIDTH       = 32;
   localparam int WORD_SIZE           = 4;
   localparam int WORD_PER_BLOCK      = 16;
   localparam int L2_BUS_WIDTH        = 32;
   localparam int WORD_WIDTH          = WORD_SIZE * 8;
   localparam int BLOCK_WIDTH         = WORD_WIDTH * WORD_PER_BLOCK;
   localparam int WORD_IDX_WIDTH      = $clog2(WORD_PER_BLOCK);
   localparam int BYTE_OFS_WIDTH      = $clog2(WORD_SIZE);
   localparam int BLOCK_ADDRESS_WIDTH = ADDRESS_WIDTH - WORD_IDX_WIDTH - BYTE_OFS_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_RESPOND = 2'd2
   } fetch_state_e;

   function automatic logic [ADDRESS_WIDTH-1:0] word_byte_addr(
      input logic [BLOCK_ADDRESS_WIDTH-1:0] blk,
      input logic [WORD_IDX_WIDTH-1:0]      idx
   );
      return {blk, idx, {BYTE_OFS_WIDTH{1'b0}}};
   endfunction

endpackage

// File: rtl/instruction_block_fetch_unit_if.sv
// Cache L2 request/response channels and the word-wide memory read port of the block fetch unit.
interface instruction_block_fetch_unit_if;
   import instruction_block_fetch_unit_pkg::*;

   logic                           ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE;
   logic                           ADDRESS_TO_L2_READY_INSTRUCTION_CACHE;
   logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_INSTRUCTION_CACHE;
   logic                           DATA_FROM_L2_VALID_INSTRUCTION_CACHE;
   logic                           DATA_FROM_L2_READY_INSTRUCTION_CACHE;
   logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_INSTRUCTION_CACHE;
   logic                           MEM_READ_VALID;
   logic                           MEM_READ_READY;
   logic [ADDRESS_WIDTH-1:0]       MEM_ADDRESS;
   logic                           MEM_DATA_VALID;
   logic [L2_BUS_WIDTH-1:0]        MEM_DATA;

   // slave: the fetch unit itself; master: the cache and memory around it
   modport slave (
      input  ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
      output ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
      input  ADDRESS_TO_L2_INSTRUCTION_CACHE,
      output DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
      input  DATA_FROM_L2_READY_INSTRUCTION_CACHE,
      output DATA_FROM_L2_INSTRUCTION_CACHE,
      output MEM_READ_VALID,
      input  MEM_READ_READY,
      output MEM_ADDRESS,
      input  MEM_DATA_VALID,
      input  MEM_DATA
   );

   modport master (
      output ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
      input  ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
      output ADDRESS_TO_L2_INSTRUCTION_CACHE,
      input  DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
      output DATA_FROM_L2_READY_INSTRUCTION_CACHE,
      input  DATA_FROM_L2_INSTRUCTION_CACHE,
      input  MEM_READ_VALID,
      output MEM_READ_READY,
      input  MEM_ADDRESS,
      output MEM_DATA_VALID,
      output MEM_DATA
   );

endinterface

// File: rtl/instruction_block_fetch_unit_block_assembly_register.sv
// Line assembly: collects returned words in order into the 512-bit line, word 0 in the top slot.
module block_assembly_register
   import instruction_block_fetch_unit_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   clr_i,
   input  logic                   en_i,
   input  logic                   data_valid_i,
   input  logic [WORD_WIDTH-1:0]  data_i,
   output logic [BLOCK_WIDTH-1:0] line_o,
   output logic                   last_o
);

   logic [WORD_IDX_WIDTH-1:0] rcv_cnt_q, rcv_cnt_d;
   logic [BLOCK_WIDTH-1:0]    line_q, line_d;
   logic                      wr;

   always_comb begin
      rcv_cnt_d = rcv_cnt_q;
      line_d    = line_q;
      wr        = en_i & data_valid_i;
      if (clr_i) begin
         rcv_cnt_d = '0;
      end else if (wr) begin
         rcv_cnt_d = rcv_cnt_q + 1'b1;
      end
      for (int i = 0; i < WORD_PER_BLOCK; i++) begin
         if (wr && (rcv_cnt_q == i[WORD_IDX_WIDTH-1:0])) begin
            line_d[BLOCK_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH] = data_i;
         end
      end
   end

   assign last_o = wr && (rcv_cnt_q == WORD_IDX_WIDTH'(WORD_PER_BLOCK - 1));
   assign line_o = line_q;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         rcv_cnt_q <= '0;
         line_q    <= '0;
      end else begin
         rcv_cnt_q <= rcv_cnt_d;
         line_q    <= line_d;
      end
   end

endmodule

// File: rtl/instruction_block_fetch_unit.sv
// Block fetch unit: turns one cache block request into 16 word reads and returns the assembled line.
// Optional one-entry request buffer enabled by defining REQUEST_BUFFER_EN.
//
// state      | meaning
// ST_IDLE    | waiting for a block request from the cache
// ST_FETCH   | issuing word reads and collecting returns
// ST_RESPOND | line valid to the cache, waiting for its ready
module instruction_block_fetch_unit
   import instruction_block_fetch_unit_pkg::*;
(
   input  logic                          CLK,
   input  logic                          RSTN,
   instruction_block_fetch_unit_if.slave bus
);

   fetch_state_e                   state_q, state_d;
   logic [WORD_IDX_WIDTH:0]        issue_cnt_q, issue_cnt_d;
   logic [BLOCK_ADDRESS_WIDTH-1:0] blk_addr_q, blk_addr_d;
   logic                           live_q, live_d;
   logic                           req_ready, req_hs, rd_valid, issue_hs;
   logic                           resp_valid, resp_hs, rcv_clr, rcv_last;
   logic [BLOCK_WIDTH-1:0]         line;
`ifdef REQUEST_BUFFER_EN
   logic                           buf_valid_q, buf_valid_d;
   logic [BLOCK_ADDRESS_WIDTH-1:0] buf_addr_q, buf_addr_d;
`endif

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      blk_addr_d  = blk_addr_q;
      live_d      = 1'b1;
      rcv_clr     = 1'b0;
`ifdef REQUEST_BUFFER_EN
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      req_ready   = live_q && ((state_q == ST_IDLE) || !buf_valid_q);
`else
      req_ready   = live_q && (state_q == ST_IDLE);
`endif
      req_hs      = bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE && req_ready;
      rd_valid    = (state_q == ST_FETCH) && !issue_cnt_q[WORD_IDX_WIDTH];
      issue_hs    = rd_valid && bus.MEM_READ_READY;
      resp_valid  = (state_q == ST_RESPOND);
      resp_hs     = resp_valid && bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE;

      case (state_q)
         ST_IDLE: begin
            if (req_hs) begin
               blk_addr_d  = bus.ADDRESS_TO_L2_INSTRUCTION_CACHE;
               issue_cnt_d = '0;
               rcv_clr     = 1'b1;
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (issue_hs) issue_cnt_d = issue_cnt_q + 1'b1;
            if (rcv_last) state_d = ST_RESPOND;
         end
         ST_RESPOND: begin
            if (resp_hs) begin
               state_d = ST_IDLE;
`ifdef REQUEST_BUFFER_EN
               // A waiting request, buffered or arriving right now, skips IDLE.
               if (buf_valid_q || req_hs) begin
                  blk_addr_d  = buf_valid_q ? buf_addr_q : bus.ADDRESS_TO_L2_INSTRUCTION_CACHE;
                  buf_valid_d = 1'b0;
                  issue_cnt_d = '0;
                  rcv_clr     = 1'b1;
                  state_d     = ST_FETCH;
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef REQUEST_BUFFER_EN
      if (req_hs && (state_q != ST_IDLE) && !resp_hs) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = bus.ADDRESS_TO_L2_INSTRUCTION_CACHE;
      end
`endif
   end

   block_assembly_register u_block_assembly_register (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .clr_i        (rcv_clr),
      .en_i         (state_q == ST_FETCH),
      .data_valid_i (bus.MEM_DATA_VALID),
      .data_i       (bus.MEM_DATA),
      .line_o       (line),
      .last_o       (rcv_last)
   );

   assign bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = req_ready;
   assign bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE  = resp_valid;
   assign bus.DATA_FROM_L2_INSTRUCTION_CACHE        = resp_valid ? line : '0;
   assign bus.MEM_READ_VALID                        = rd_valid;
   assign bus.MEM_ADDRESS = rd_valid ? word_byte_addr(blk_addr_q, issue_cnt_q[WORD_IDX_WIDTH-1:0])
                                     : '0;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         blk_addr_q  <= '0;
         live_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         blk_addr_q  <= blk_addr_d;
         live_q      <= live_d;
      end
   end

`ifdef REQUEST_BUFFER_EN
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
      end
   end
`endif

endmodule
